cam_reg_sequencer: RTL and testbench

Parametrised camera-register init sequencer. Stores up to `PROFILES` command lists, each `DEPTH` entries of `{reg_addr, reg_data}`, in a sub-ROM. On `start` it streams the selected profile to the SCCB/I2C master over a valid/ready handshake, executing millisecond delay pseudo-commands in-line. It sits between the top-level camera control and the SCCB master, and raises `done` when the end marker is reached.

---
 rtl/cam_seq_pkg.sv | 57 +++++
 rtl/cam_seq_rom.sv | 35 +++
 rtl/cam_reg_sequencer.sv | 133 +++++++++++++
 tb/tb_cam_reg_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_seq_pkg.sv
// Shared types, constants and profile tables for the camera register init sequencer.
// Each table entry is {addr, data}: all-ones is the END marker, addr all-ones with
// any other data is a delay of <data> milliseconds, anything else is a register write.
package cam_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int CAM_ADDR_W = 8;
  localparam int CAM_DATA_W = 8;

  typedef struct packed {
    logic [CAM_ADDR_W-1:0] addr;
    logic [CAM_DATA_W-1:0] data;
  } cmd_t;

  localparam cmd_t                  CMD_END    = '1;
  localparam logic [CAM_ADDR_W-1:0] DELAY_ADDR = '1;

  localparam int TBL_LEN = 16;
  localparam int TBL_AW  = 4;

  // Profile 0: OV7670 QVGA RGB565 (soft reset, settle 5 ms, then format/scaling setup)
  localparam cmd_t PROF0 [TBL_LEN] = '{
    16'h1280, 16'hFF05, 16'h1204, 16'h1100, 16'h0C04, 16'h3E19, 16'h4010, 16'h3A04,
    16'h1716, 16'h1804, 16'h3200, 16'h1902, 16'h1A7A, 16'h0300, 16'hFF00, 16'hFFFF
  };

  // Profile 1: OV7670 YUV422
  localparam cmd_t PROF1 [TBL_LEN] = '{
    16'h1280, 16'h1200, 16'h1100, 16'h0C00, 16'h3E00, 16'h40C0, 16'h3A04, 16'h3D88,
    16'h1714, 16'h1802, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF
  };

  // Width of the profile select port; a single-profile build still gets one bit.
  function automatic int prof_w(input int profiles);
    return (profiles > 1) ? $clog2(profiles) : 1;
  endfunction

  // Table lookup; anything outside the stored tables reads as END.
  function automatic cmd_t rom_entry(input int p, input int i);
    cmd_t e;
    e = CMD_END;
    if (i >= 0 && i < TBL_LEN) begin
      if (p == 0)      e = PROF0[i[TBL_AW-1:0]];
      else if (p == 1) e = PROF1[i[TBL_AW-1:0]];
    end
    return e;
  endfunction

endpackage

// File: rtl/cam_seq_rom.sv
// Command ROM: registered read of rom[profile][index] with one cycle of latency.
// Table entries are widened to ADDR_W/DATA_W keeping the all-ones markers intact.
module cam_seq_rom
  import cam_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int PROFILES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [prof_w(PROFILES)-1:0] profile,
  input  logic [$clog2(DEPTH)-1:0]   index,
  output logic [ADDR_W+DATA_W-1:0]   entry
);

  cmd_t              raw;
  logic [ADDR_W-1:0] addr_x;
  logic [DATA_W-1:0] data_x;

  // Look up the table entry and stretch the marker fields to the configured widths
  always_comb begin
    raw    = rom_entry(int'(profile), int'(index));
    addr_x = (raw.addr == DELAY_ADDR)   ? '1 : ADDR_W'(raw.addr);
    data_x = (raw.data == CMD_END.data) ? '1 : DATA_W'(raw.data);
  end

  // Output register provides the one-cycle read latency the FETCH state waits out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry <= '0;
    else     entry <= {addr_x, data_x};
  end

endmodule

// File: rtl/cam_reg_sequencer.sv
// Camera register init sequencer: streams a selected command profile to the SCCB
// master over valid/ready, handling END and millisecond DELAY entries.
// Build option: define CAM_SEQ_DELAY_EN to execute DELAY entries with a real wait;
// without it DELAY entries are skipped and no wait counter is built.
module cam_reg_sequencer
  import cam_seq_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 64,
  parameter int PROFILES     = 2,
  parameter int TICKS_PER_MS = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [prof_w(PROFILES)-1:0] profile,
  output logic                        cmd_valid,
  output logic [ADDR_W+DATA_W-1:0]    cmd_data,
  input  logic                        cmd_ready,
  output logic [$clog2(DEPTH)-1:0]    cmd_index,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = prof_w(PROFILES);

  state_t                   state, state_nx;
  logic [IW-1:0]            index_q;
  logic [PW-1:0]            prof_q, prof_sel;
  logic [ADDR_W+DATA_W-1:0] rom_q, data_q;
  logic                     is_end, is_delay, is_last, advance;

  cam_seq_rom #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PROFILES(PROFILES)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .profile(prof_q),
    .index  (index_q),
    .entry  (rom_q)
  );

  assign is_end   = (rom_q == '1);
  assign is_delay = (rom_q[ADDR_W+DATA_W-1 -: ADDR_W] == '1) && !is_end;
  assign is_last  = (index_q == IW'(DEPTH-1));
  assign prof_sel = (int'(profile) >= PROFILES) ? '0 : profile;

`ifdef CAM_SEQ_DELAY_EN
  localparam int CW = $clog2(255*TICKS_PER_MS+1);

  logic [CW-1:0] wait_q;
  logic          wait_zero;

  assign wait_zero = (wait_q == '0);

  // Load n*TICKS_PER_MS when a delay is decoded and count it down while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_q <= '0;
    else if (state == S_DECODE && is_delay)
      wait_q <= CW'(rom_q[DATA_W-1:0]) * CW'(TICKS_PER_MS);
    else if (state == S_WAIT && !wait_zero)
      wait_q <= wait_q - CW'(1);
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; start overrides everything and restarts from index 0
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      S_IDLE:  ;
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        if (is_end) begin
          state_nx = S_DONE;
        end else if (is_delay) begin
`ifdef CAM_SEQ_DELAY_EN
          if (rom_q[DATA_W-1:0] != '0) state_nx = S_WAIT;
          else                         advance  = 1'b1;
`else
          advance = 1'b1;
`endif
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: if (cmd_ready) advance = 1'b1;
`ifdef CAM_SEQ_DELAY_EN
      S_WAIT:  if (wait_zero) advance = 1'b1;
`endif
      S_DONE:  ;
      default: state_nx = S_IDLE;
    endcase
    if (advance) state_nx = is_last ? S_DONE : S_FETCH;
    if (start)   state_nx = S_FETCH;
  end

  // Index/profile bookkeeping and the held command word for the current write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      prof_q  <= '0;
      data_q  <= '0;
    end else if (start) begin
      index_q <= '0;
      prof_q  <= prof_sel;
    end else begin
      if (advance && !is_last)
        index_q <= index_q + IW'(1);
      if (state == S_DECODE && !is_end && !is_delay)
        data_q <= rom_q;
    end
  end

  assign cmd_valid = (state == S_ISSUE);
  assign cmd_data  = data_q;
  assign cmd_index = index_q;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Testbench for cam_reg_sequencer: scoreboarded write stream, timing, backpressure,
// restart, DEPTH-limited run without END, and asynchronous reset.
module tb_cam_reg_sequencer;

  localparam int TICKS = 10;
`ifdef CAM_SEQ_DELAY_EN
  localparam int GAP_0_TO_2 = 56;
`else
  localparam int GAP_0_TO_2 = 5;
`endif

  typedef struct {
    logic [15:0] data;
    int          idx;
  } wr_t;

  localparam logic [15:0] P0_DATA [13] = '{16'h1280, 16'h1204, 16'h1100, 16'h0C04, 16'h3E19,
                                           16'h4010, 16'h3A04, 16'h1716, 16'h1804, 16'h3200,
                                           16'h1902, 16'h1A7A, 16'h0300};
  localparam int          P0_IDX  [13] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
  localparam logic [15:0] P1_DATA [10] = '{16'h1280, 16'h1200, 16'h1100, 16'h0C00, 16'h3E00,
                                           16'h40C0, 16'h3A04, 16'h3D88, 16'h1714, 16'h1802};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start4 = 1'b0;
  logic [0:0]  profile = 1'b0, profile4 = 1'b0;
  logic        cmd_ready = 1'b0, cmd_ready4 = 1'b0;
  logic        cmd_valid, cmd_valid4;
  logic [15:0] cmd_data, cmd_data4;
  logic [5:0]  cmd_index;
  logic [1:0]  cmd_index4;
  logic        busy, busy4, done, done4;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  wr_cnt = 0, wr_cnt4 = 0;
  int  acc_cyc [64];
  wr_t sb[$], sb4[$];

  cam_reg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(64), .PROFILES(2), .TICKS_PER_MS(TICKS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .profile(profile),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .busy(busy), .done(done)
  );

  cam_reg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(4), .PROFILES(2), .TICKS_PER_MS(TICKS)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .profile(profile4),
    .cmd_valid(cmd_valid4), .cmd_data(cmd_data4), .cmd_ready(cmd_ready4),
    .cmd_index(cmd_index4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle on unit 0 (main DUT) or unit 1 (DEPTH=4 DUT) and load expectations
  task automatic applyStimulus(input int unit, input logic [0:0] p);
    step();
    if (unit == 0) begin
      sb.delete();
      wr_cnt = 0;
      if (p == 1'b0)
        for (int i = 0; i < 13; i++) sb.push_back(wr_t'{P0_DATA[i], P0_IDX[i]});
      else
        for (int i = 0; i < 10; i++) sb.push_back(wr_t'{P1_DATA[i], i});
      profile = p;
      start   = 1'b1;
    end else begin
      sb4.delete();
      wr_cnt4 = 0;
      for (int i = 0; i < 4; i++) sb4.push_back(wr_t'{P1_DATA[i], i});
      profile4 = p;
      start4   = 1'b1;
    end
    step();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic waitDone(input int unit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      if ((unit == 0 && done) || (unit == 1 && done4)) begin
        at = cyc;
        break;
      end
      step();
    end
    checkOutput(tag, (unit == 0) ? 32'(done) : 32'(done4), 1);
  endtask

  // Scoreboard for the main DUT: every accepted command must match the next expected write
  always @(negedge clk) begin
    if (!rst && !start && cmd_valid && cmd_ready) begin
      checkOutput("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        wr_t w;
        w = sb.pop_front();
        checkOutput("wr_data", 32'(cmd_data), 32'(w.data));
        checkOutput("wr_index", 32'(cmd_index), w.idx);
      end
      acc_cyc[cmd_index] = cyc;
      wr_cnt++;
    end
  end

  // Scoreboard for the DEPTH=4 DUT
  always @(negedge clk) begin
    if (!rst && !start4 && cmd_valid4 && cmd_ready4) begin
      checkOutput("sb4_has_entry", 32'(sb4.size() > 0), 1);
      if (sb4.size() > 0) begin
        wr_t w;
        w = sb4.pop_front();
        checkOutput("wr4_data", 32'(cmd_data4), 32'(w.data));
        checkOutput("wr4_index", 32'(cmd_index4), w.idx);
      end
      wr_cnt4++;
    end
  end

  initial begin
    int t_done;
    bit found;

    #2 rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_valid", 32'(cmd_valid), 0);
    checkOutput("rst_data", 32'(cmd_data), 0);
    checkOutput("rst_index", 32'(cmd_index), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    rst = 1'b0;

    // Profile 0 with ready tied high: latency, full stream, delay gap, done timing
    cmd_ready = 1'b1;
    applyStimulus(0, 1'b0);
    checkOutput("t1_busy", 32'(busy), 1);
    step();
    checkOutput("t1_valid_c2", 32'(cmd_valid), 0);
    step();
    checkOutput("t1_valid_c3", 32'(cmd_valid), 1);
    checkOutput("t1_data_c3", 32'(cmd_data), 32'h1280);
    waitDone(0, "t1_done", t_done);
    checkOutput("t1_writes", wr_cnt, 13);
    checkOutput("t1_sb_empty", sb.size(), 0);
    checkOutput("t1_gap_0_2", acc_cyc[2] - acc_cyc[0], GAP_0_TO_2);
    checkOutput("t1_done_lat", t_done - acc_cyc[13], 5);
    repeat (3) step();
    checkOutput("t1_done_held", 32'(done), 1);
    checkOutput("t1_idle_busy", 32'(busy), 0);

    // Backpressure at index 2 for 10 cycles
    applyStimulus(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_valid && cmd_index == 6'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    cmd_ready = 1'b0;
    checkOutput("t2_reach_idx2", 32'(found), 1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t2_hold_data", 32'(cmd_data), 32'h1204);
      checkOutput("t2_hold_index", 32'(cmd_index), 2);
      checkOutput("t2_hold_valid", 32'(cmd_valid), 1);
      step();
    end
    cmd_ready = 1'b1;
    step();
    checkOutput("t2_valid_drop", 32'(cmd_valid), 0);
    checkOutput("t2_next_index", 32'(cmd_index), 3);
    waitDone(0, "t2_done", t_done);
    checkOutput("t2_writes", wr_cnt, 13);
    checkOutput("t2_sb_empty", sb.size(), 0);

    // Restart into profile 1 while index 5 of profile 0 is pending
    applyStimulus(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_valid && cmd_index == 6'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    cmd_ready = 1'b0;
    checkOutput("t3_reach_idx5", 32'(found), 1);
    applyStimulus(0, 1'b1);
    checkOutput("t3_valid_dropped", 32'(cmd_valid), 0);
    checkOutput("t3_index_reset", 32'(cmd_index), 0);
    cmd_ready = 1'b1;
    step();
    step();
    checkOutput("t3_valid_c3", 32'(cmd_valid), 1);
    checkOutput("t3_data_c3", 32'(cmd_data), 32'h1280);
    waitDone(0, "t3_done", t_done);
    checkOutput("t3_writes", wr_cnt, 10);
    checkOutput("t3_sb_empty", sb.size(), 0);

    // DEPTH=4 instance, profile 1 has no END in its first four entries
    cmd_ready4 = 1'b1;
    applyStimulus(1, 1'b1);
    waitDone(1, "t4_done", t_done);
    checkOutput("t4_writes", wr_cnt4, 4);
    checkOutput("t4_index_held", 32'(cmd_index4), 3);
    checkOutput("t4_sb_empty", sb4.size(), 0);
    checkOutput("t4_busy", 32'(busy4), 0);

    // Asynchronous reset while a command is pending
    cmd_ready = 1'b0;
    applyStimulus(0, 1'b0);
    step();
    step();
    checkOutput("t5_valid_before", 32'(cmd_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(cmd_valid), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    checkOutput("t5_rst_done", 32'(done), 0);
    checkOutput("t5_rst_data", 32'(cmd_data), 0);
    checkOutput("t5_rst_index", 32'(cmd_index), 0);
    sb.delete();
    step();
    rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (5) step();
    checkOutput("t5_stay_idle_busy", 32'(busy), 0);
    checkOutput("t5_stay_idle_valid", 32'(cmd_valid), 0);
    checkOutput("t5_stay_idle_done", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
